// File: rtl/cordic_result_buffer.sv
// Result FIFO and byte serialiser behind the CORDIC datapath; falling-edge state, async active-low reset.
// Define CORDIC_RESULT_TAG_EN to add a third {mode, seq} tag byte per frame and per-entry sequence storage.
module cordic_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clka,
  input  logic                     reset_n,
  input  logic                     res_valid,
  input  logic                     res_mode,
  input  logic [7:0]               res_a,
  input  logic [7:0]               res_b,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

`ifdef CORDIC_RESULT_TAG_EN
  localparam int EW = 24;
`else
  localparam int EW = 17;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BYTE0 = 2'd1;
  localparam logic [1:0] ST_BYTE1 = 2'd2;
`ifdef CORDIC_RESULT_TAG_EN
  localparam logic [1:0] ST_TAG   = 2'd3;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full_reg;
  logic          ovf_reg;
  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [EW-1:0] hold_reg;
  logic [EW-1:0] wr_entry;
  logic          push;
  logic          drop;
  logic          pop;
  logic          empty;
  logic          handshake;

  // Admission uses the registered full flag, so a same-edge pop never makes room.
  assign empty     = (count_reg == '0);
  assign push      = res_valid && !full_reg;
  assign drop      = res_valid && full_reg;
  assign tx_valid  = (state_reg != ST_IDLE);
  assign handshake = tx_valid && tx_ready;

  assign fifo_count = count_reg;
  assign fifo_full  = full_reg;
  assign overflow   = ovf_reg;

`ifdef CORDIC_RESULT_TAG_EN
  logic [6:0] seq_reg;

  assign wr_entry = {seq_reg, res_mode, res_a, res_b};

  // Every strobe consumes a sequence number, dropped or not, so gaps reveal losses.
  always_ff @(negedge clka or negedge reset_n) begin
    if (!reset_n) begin
      seq_reg <= 7'd0;
    end else if (res_valid) begin
      seq_reg <= seq_reg + 7'd1;
    end
  end
`else
  logic unused_mode;

  assign wr_entry    = {res_mode, res_a, res_b};
  assign unused_mode = hold_reg[16];
`endif

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_BYTE0;
        end
      end
      ST_BYTE0: begin
        if (handshake) state_next = ST_BYTE1;
      end
      ST_BYTE1: begin
        if (handshake) begin
`ifdef CORDIC_RESULT_TAG_EN
          state_next = ST_TAG;
`else
          if (!empty) begin
            pop        = 1'b1;
            state_next = ST_BYTE0;
          end else begin
            state_next = ST_IDLE;
          end
`endif
        end
      end
`ifdef CORDIC_RESULT_TAG_EN
      ST_TAG: begin
        if (handshake) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = ST_BYTE0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    case (state_reg)
      ST_BYTE0: tx_data = hold_reg[15:8];
      ST_BYTE1: tx_data = hold_reg[7:0];
`ifdef CORDIC_RESULT_TAG_EN
      ST_TAG:   tx_data = {hold_reg[16], hold_reg[23:17]};
`endif
      default:  tx_data = 8'h00;
    endcase
  end

  // Storage array carries no reset so it can map onto RAM.
  always_ff @(negedge clka) begin
    if (push) mem[wr_ptr_reg] <= wr_entry;
  end

  always_ff @(negedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      hold_reg   <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_CNT);
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        hold_reg   <= mem[rd_ptr_reg];
      end
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_result_buffer.sv
// Scoreboard bench for cordic_result_buffer: stimulus queues expected bytes, a monitor checks each handshake.
module tb_cordic_result_buffer;

  logic       clka;
  logic       reset_n;
  logic       res_valid;
  logic       res_mode;
  logic [7:0] res_a;
  logic [7:0] res_b;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       overflow;
  logic       ovf_clr;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
`ifdef CORDIC_RESULT_TAG_EN
  logic [6:0] seq_model = 7'd0;
`endif

  cordic_result_buffer #(.DEPTH(4)) dut (
    .clka       (clka),
    .reset_n    (reset_n),
    .res_valid  (res_valid),
    .res_mode   (res_mode),
    .res_a      (res_a),
    .res_b      (res_b),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  // DUT acts on falling edges; the bench drives and samples around rising edges.
  initial clka = 1'b1;
  always #5 clka = ~clka;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic strobe(input logic [7:0] a, input logic [7:0] b, input logic m, input bit accept);
    res_valid = 1'b1;
    res_a     = a;
    res_b     = b;
    res_mode  = m;
    if (accept) begin
      exp_q.push_back(a);
      exp_q.push_back(b);
`ifdef CORDIC_RESULT_TAG_EN
      exp_q.push_back({m, seq_model});
`endif
    end
`ifdef CORDIC_RESULT_TAG_EN
    seq_model = seq_model + 7'd1;
`endif
    @(posedge clka);
    res_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400; i++) begin
      @(posedge clka);
      if (exp_q.size() == 0 && !tx_valid) break;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  initial begin
    forever begin
      @(posedge clka);
      #1;
      if (reset_n && tx_valid && tx_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL tx_byte: got 0x%0h expected no byte", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            fails++;
            $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_data, e);
          end else begin
            $display("ok   tx_byte: 0x%0h", tx_data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    res_valid = 1'b0;
    res_mode  = 1'b0;
    res_a     = 8'h00;
    res_b     = 8'h00;
    tx_ready  = 1'b0;
    ovf_clr   = 1'b0;
    repeat (2) @(posedge clka);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_count", fifo_count, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clka);
    reset_n = 1'b1;
    @(posedge clka);

    // Single result, host always ready
    tx_ready = 1'b1;
    strobe(8'h26, 8'h1D, 1'b0, 1'b1);
    #1;
    chk("single_count_after_push", fifo_count, 1);
    chk("single_valid_1edge", tx_valid, 0);
    @(posedge clka);
    #1;
    chk("single_valid_2edge", tx_valid, 1);
    wait_drain("single_drain");
    #1;
    chk("single_count_end", fifo_count, 0);
    chk("single_idle_end", tx_valid, 0);

    // Backpressure held for 5 cycles in BYTE0
    @(posedge clka);
    tx_ready = 1'b0;
    strobe(8'h26, 8'h1D, 1'b1, 1'b1);
    @(posedge clka);
    for (int i = 0; i < 5; i++) begin
      @(posedge clka);
      #1;
      chk("stall_data", tx_data, 8'h26);
      chk("stall_valid", tx_valid, 1);
    end
    @(posedge clka);
    tx_ready = 1'b1;
    @(posedge clka);
    #1;
    chk("stall_next_byte", tx_data, 8'h1D);
    wait_drain("stall_drain");

    // Fill and overflow: first goes to holder, four fill, sixth dropped
    @(posedge clka);
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      strobe(8'h10 + 8'(k), 8'hA0 + 8'(k), k[0], k < 5);
    end
    #1;
    chk("fill_count", fifo_count, 4);
    chk("fill_full", fifo_full, 1);
    chk("fill_overflow", overflow, 1);
    @(posedge clka);
    ovf_clr = 1'b1;
    @(posedge clka);
    ovf_clr = 1'b0;
    #1;
    chk("ovf_cleared", overflow, 0);
    chk("ovf_clr_count", fifo_count, 4);

    // Strobe on the edge of a pop while full: dropped, count 4 -> 3
    @(posedge clka);
    tx_ready = 1'b1;
    @(posedge clka);
`ifdef CORDIC_RESULT_TAG_EN
    @(posedge clka);
`endif
    strobe(8'hEE, 8'hEE, 1'b0, 1'b0);
    #1;
    chk("pushpop_full_count", fifo_count, 3);
    chk("pushpop_full_overflow", overflow, 1);
    wait_drain("fill_drain");
    #1;
    chk("fill_drain_count", fifo_count, 0);
    @(posedge clka);
    ovf_clr = 1'b1;
    @(posedge clka);
    ovf_clr = 1'b0;

`ifdef CORDIC_RESULT_TAG_EN
    // Sequence wrap: 130 strobes three cycles apart, none dropped
    for (int k = 0; k < 130; k++) begin
      strobe(8'(k), 8'(255 - k), k[1], 1'b1);
      repeat (2) @(posedge clka);
    end
    wait_drain("wrap_drain");
    #1;
    chk("wrap_no_overflow", overflow, 0);
`endif

    // Reset during BYTE1 with two entries queued
    @(posedge clka);
    tx_ready = 1'b0;
    strobe(8'h31, 8'h41, 1'b0, 1'b1);
    strobe(8'h32, 8'h42, 1'b0, 1'b1);
    strobe(8'h33, 8'h43, 1'b1, 1'b1);
    tx_ready = 1'b1;
    @(posedge clka);
    tx_ready = 1'b0;
    #1;
    chk("pre_reset_count", fifo_count, 2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", tx_valid, 0);
    chk("midrst_data", tx_data, 8'h00);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_full", fifo_full, 0);
    exp_q.delete();
`ifdef CORDIC_RESULT_TAG_EN
    seq_model = 7'd0;
`endif
    @(posedge clka);
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    repeat (5) @(posedge clka);
    #1;
    chk("post_rst_silent", tx_valid, 0);
    chk("post_rst_count", fifo_count, 0);
    @(posedge clka);
    strobe(8'h5A, 8'hC3, 1'b1, 1'b1);
    wait_drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
